// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync: STAGES-deep synchronizer for a Gray-coded FIFO pointer,
// with registered binary decode, change/step pulse and jump detection.
//
// Ports:
//   clk       destination-domain clock, rising edge
//   rst       asynchronous reset, active low
//   gray_in   Gray pointer from the foreign domain (asynchronous)
//   err_clr   synchronous clear of sync_err
//   gray_out  synchronized Gray pointer (last synchronizer stage)
//   bin_out   registered binary equivalent of gray_out
//   changed   one-cycle pulse when bin_out takes a new value
//   step      modulo difference new - old bin_out while changed, else 0
//   ready     high once the pipeline has flushed after reset
//   sync_err  sticky: synchronized pointer moved by more than one bit
module gray_ptr_sync #(
  parameter int WIDTH  = 3,
  parameter int STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [WIDTH:0] gray_in,
  input  logic           err_clr,
  output logic [WIDTH:0] gray_out,
  output logic [WIDTH:0] bin_out,
  output logic           changed,
  output logic [WIDTH:0] step,
  output logic           ready,
  output logic           sync_err
);

  localparam int PW = WIDTH + 1;
  localparam int CW = $clog2(STAGES + 2);

  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("gray_ptr_sync: STAGES must be in 2..4");
  end

  logic [WIDTH:0] sync_q [STAGES];
  logic [WIDTH:0] prev_gray;
  logic [WIDTH:0] bin_next;
  logic [WIDTH:0] gdiff;
  logic [CW-1:0]  warm_cnt;
  logic           moved;
  logic           multi;

  // Plain flop chain: nothing between gray_in and the first stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign gray_out = sync_q[STAGES-1];

  // bin[i] is the XOR of all Gray bits at or above i.
  always_comb begin
    bin_next = '0;
    for (int i = 0; i < PW; i++) begin
      bin_next[i] = ^(gray_out >> i);
    end
  end

  // More than one bit set <=> clearing the lowest set bit leaves some.
  assign gdiff = gray_out ^ prev_gray;
  assign multi = |(gdiff & (gdiff - PW'(1)));
  assign moved = (bin_next != bin_out);

  // Warm-up: ready rises on edge STAGES+1 after release, then holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      warm_cnt <= '0;
      ready    <= 1'b0;
    end else if (!ready) begin
      warm_cnt <= warm_cnt + CW'(1);
      ready    <= (warm_cnt == CW'(STAGES));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_gray <= '0;
      bin_out   <= '0;
      changed   <= 1'b0;
      step      <= '0;
      sync_err  <= 1'b0;
    end else begin
      prev_gray <= gray_out;
      bin_out   <= bin_next;
      changed   <= ready && moved;
      step      <= (ready && moved) ? bin_next - bin_out : '0;
      // A new jump outranks a coincident clear.
      if (ready && multi) begin
        sync_err <= 1'b1;
      end else if (err_clr) begin
        sync_err <= 1'b0;
      end
    end
  end

endmodule
